delay_capture_ctrl: RTL
=======================

Name: delay_capture_ctrl

Overview:
- Programmable-latency capture controller: samples DIN on a start request and drives it onto Q exactly DELAY+1 clock edges later.
- Sequences a single output register, turning a plain D-type capture into a scheduled, cancellable update.
- Sits between a requester (start/cancel handshake) and downstream logic that consumes Q and the DONE strobe.

Parameters:
- DATA_W, 1, width of DIN/Q
- CNT_W, 8, width of DELAY and internal down-counter

Ports:
- CLK  in  1  clock, all state changes on rising edge
- n_res  in  1  asynchronous, active-low reset
- START  in  1  request: capture DIN, schedule Q update
- DELAY  in  CNT_W  extra cycles to wait, sampled with START
- DIN  in  DATA_W  data captured on accepted START
- CANCEL  in  1  abort a pending update
- Q  out  DATA_W  scheduled output register
- BUSY  out  1  high while an update is pending (WAIT or FIRE)
- DONE  out  1  one-cycle strobe, high in the cycle Q takes its new value
- OVERRUN  out  1  one-cycle strobe: START arrived while busy and was dropped

Behaviour:
- Reset (n_res=0, asynchronous, immediate): Q=0, DONE=0, OVERRUN=0, BUSY=0, state=IDLE, counter=0, hold register=0.
- States: IDLE, WAIT, FIRE. BUSY=1 in WAIT and FIRE (combinational from state).
- IDLE:
  - START=1 and CANCEL=0: hold<=DIN, cnt<=DELAY; go to FIRE if DELAY==0, else WAIT.
  - START with CANCEL in the same cycle: nothing captured, stay IDLE.
- WAIT:
  - Each edge cnt<=cnt-1; when cnt==1 at an edge, go to FIRE.
  - CANCEL=1: go to IDLE, Q unchanged, no DONE.
- FIRE: at next edge Q<=hold, DONE<=1 for exactly one cycle, go to IDLE. CANCEL is ignored here (update completes).
- Latency: START sampled at edge E0 gives the Q update and DONE rising at edge E(DELAY+1). DELAY=0 gives 1 edge; DELAY=255 gives 256 edges.
- START while BUSY (no RETRIGGER): dropped, OVERRUN<=1 for one cycle; pending update unaffected.
- CANCEL and START together in WAIT: CANCEL wins; START is dropped without OVERRUN.
- Back-to-back: START accepted in the cycle DONE is high (state IDLE), so sustained throughput is one update per DELAY+2 cycles.
- Counter never wraps: it only loads from DELAY and decrements down to 1.
- Reset asserted mid-WAIT: pending update discarded, Q forced to 0.

Optional Feature:
- Macro: DELAY_CAPTURE_RETRIGGER_EN
- Defined: START in WAIT (without CANCEL) reloads hold<=DIN and cnt<=DELAY (FIRE if DELAY==0). No OVERRUN in WAIT; START in FIRE still raises OVERRUN.
- Undefined: behaviour as above; START while BUSY always raises OVERRUN.

Decomposition:
- Package delay_capture_pkg:
  - state enum (IDLE, WAIT, FIRE), 2-bit encoding
  - default constants DATA_W_DEF=1, CNT_W_DEF=8
- One sub-module, delay_down_cnt: loadable CNT_W down-counter with load, dec and is_one outputs. The FSM and output register stay in the top.

Test Plan:
- Reset then START, DIN=1, DELAY=0 on negedge -> Q=1 and DONE=1 after the next posedge only; BUSY high for exactly 1 cycle.
- DIN=1, DELAY=3 -> Q stays 0 for edges 1-3, Q=1 with DONE pulse at edge 4; DONE is low one cycle later.
- DIN=1, DELAY=5, CANCEL after 2 edges -> BUSY drops next edge; Q stays 0, no DONE.
- DELAY=4 pending, second START with DIN=0 after 1 edge -> OVERRUN one cycle; Q=1 at edge 5 (undefined macro). With macro defined: no OVERRUN, Q=0 at edge 1+5=6.
- DELAY=6, drop n_res mid-WAIT for 15ps -> Q=0, BUSY=0 within the reset window; no DONE afterwards.
- Update completes with DONE; new START (DIN=0, DELAY=1) applied in the DONE cycle -> accepted, Q=0 two edges later, no OVERRUN.

Source files
------------

// File: rtl/delay_capture_pkg.sv
// ---------------------------------------------------------------------------
// delay_capture_pkg
// Shared types and defaults for the delay capture controller.
//   state_e    : controller state (IDLE, WAIT, FIRE), 2-bit encoding
//   DATA_W_DEF : default data width of DIN/Q
//   CNT_W_DEF  : default width of DELAY and the internal down-counter
// Optional feature macro used by the top: DELAY_CAPTURE_RETRIGGER_EN
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package delay_capture_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      FIRE = 2'd2
   } state_e;

   localparam int DATA_W_DEF = 1;
   localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/delay_down_cnt.sv
// ---------------------------------------------------------------------------
// delay_down_cnt
// Loadable down-counter used to time the WAIT phase of the controller.
// Ports:
//   clk_i      : clock, rising edge
//   n_res_i    : asynchronous active-low reset (count cleared to 0)
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement request
//   is_one_o   : current count equals 1
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module delay_down_cnt
   import delay_capture_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             n_res_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             is_one_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Decrement saturates at zero so the count can never wrap around.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge n_res_i) begin
      if (!n_res_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/delay_capture_ctrl.sv
// ---------------------------------------------------------------------------
// delay_capture_ctrl
// Programmable-latency capture controller: DIN is captured on an accepted
// START and driven onto Q exactly DELAY+1 rising edges later, unless the
// pending update is cancelled first.
// Ports:
//   CLK     : clock, rising edge
//   n_res   : asynchronous active-low reset
//   START   : request to capture DIN and schedule a Q update
//   DELAY   : extra cycles to wait, sampled with START
//   DIN     : data captured on an accepted START
//   CANCEL  : abort a pending update (ignored once in FIRE)
//   Q       : scheduled output register
//   BUSY    : high while an update is pending (WAIT or FIRE)
//   DONE    : one-cycle strobe in the cycle Q takes its new value
//   OVERRUN : one-cycle strobe, a START was dropped because we were busy
// Configuration macro: DELAY_CAPTURE_RETRIGGER_EN
//   When defined, START in WAIT (without CANCEL) restarts the pending
//   update with the new DIN/DELAY instead of being dropped.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module delay_capture_ctrl
   import delay_capture_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              CLK,
   input  logic              n_res,
   input  logic              START,
   input  logic [CNT_W-1:0]  DELAY,
   input  logic [DATA_W-1:0] DIN,
   input  logic              CANCEL,
   output logic [DATA_W-1:0] Q,
   output logic              BUSY,
   output logic              DONE,
   output logic              OVERRUN
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] q_q, q_d;
   logic              done_q, done_d;
   logic              overrun_q, overrun_d;
   logic              cnt_load, cnt_dec, cnt_is_one;

   delay_down_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk_i      (CLK),
      .n_res_i    (n_res),
      .load_i     (cnt_load),
      .load_val_i (DELAY),
      .dec_i      (cnt_dec),
      .is_one_o   (cnt_is_one)
   );

   // Next-state logic. A zero DELAY skips WAIT entirely so the update
   // lands one edge after acceptance; otherwise WAIT leaves for FIRE on
   // the edge where the counter reads 1.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      q_d       = q_q;
      done_d    = 1'b0;
      overrun_d = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      case (state_q)
         IDLE: begin
            if (START && !CANCEL) begin
               hold_d   = DIN;
               cnt_load = 1'b1;
               state_d  = (DELAY == '0) ? FIRE : WAIT;
            end
         end
         WAIT: begin
            // CANCEL beats a simultaneous START, which then vanishes silently.
            if (CANCEL) begin
               state_d = IDLE;
            end else begin
`ifdef DELAY_CAPTURE_RETRIGGER_EN
               if (START) begin
                  hold_d   = DIN;
                  cnt_load = 1'b1;
                  state_d  = (DELAY == '0) ? FIRE : WAIT;
               end else begin
                  cnt_dec = 1'b1;
                  if (cnt_is_one) begin
                     state_d = FIRE;
                  end
               end
`else
               overrun_d = START;
               cnt_dec   = 1'b1;
               if (cnt_is_one) begin
                  state_d = FIRE;
               end
`endif
            end
         end
         FIRE: begin
            q_d       = hold_q;
            done_d    = 1'b1;
            overrun_d = START;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge n_res) begin
      if (!n_res) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         q_q       <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         q_q       <= q_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   assign Q       = q_q;
   assign BUSY    = (state_q != IDLE);
   assign DONE    = done_q;
   assign OVERRUN = overrun_q;

endmodule
